// File: rtl/byte_stream_assembler_pkg.sv
// Shared defaults and derived widths for the byte-serial operand assembler.
package byte_stream_pkg;

  localparam int unsigned DEF_BUS_W   = 8;
  localparam int unsigned DEF_NBEATS  = 3;
  localparam int unsigned DEF_X_BEATS = 2;

  localparam int unsigned WORD_W = DEF_NBEATS * DEF_BUS_W;
  localparam int unsigned CNT_W  = $clog2(DEF_NBEATS);

endpackage

// File: rtl/byte_stream_assembler_if.sv
// Beat input handshake and X/Y word output handshake of the assembler.
interface byte_stream_assembler_if #(
  parameter int unsigned BUS_W   = 8,
  parameter int unsigned NBEATS  = 3,
  parameter int unsigned X_BEATS = 2
);

  logic                                in_valid;
  logic                                in_ready;
  logic [BUS_W-1:0]                    bus;
  logic                                out_valid;
  logic                                out_ready;
  logic [X_BEATS*BUS_W-1:0]            x;
  logic [(NBEATS-X_BEATS)*BUS_W-1:0]   y;

  modport master (
    output in_valid, bus, out_ready,
    input  in_ready, out_valid, x, y
  );

  modport slave (
    input  in_valid, bus, out_ready,
    output in_ready, out_valid, x, y
  );

endinterface

// File: rtl/byte_stream_assembler_beat_counter.sv
// Modulo-N beat counter with synchronous clear and terminal-count flag.
module beat_counter #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/byte_stream_assembler.sv
// Packs NBEATS bus beats into one word and presents it as X/Y operand fields
// from a holding register, so the next word can fill while the current waits.
module byte_stream_assembler
  import byte_stream_pkg::*;
#(
  parameter int unsigned BUS_W     = DEF_BUS_W,
  parameter int unsigned NBEATS    = DEF_NBEATS,
  parameter int unsigned X_BEATS   = DEF_X_BEATS,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  byte_stream_assembler_if.slave      io,
  output logic [$clog2(NBEATS)-1:0]   beat_cnt
);

  localparam int unsigned W  = NBEATS * BUS_W;
  localparam int unsigned XW = X_BEATS * BUS_W;
  localparam int unsigned CW = $clog2(NBEATS);

  if (NBEATS < 2 || X_BEATS < 1 || X_BEATS >= NBEATS) begin : g_bad_params
    $error("byte_stream_assembler: illegal NBEATS/X_BEATS combination");
  end

  logic [W-1:0] sr;
  logic [W-1:0] hold;
  logic [W-1:0] shifted;
  logic         valid_q;
  logic         tc;
  logic         accept;
  logic         take;

  if (MSB_FIRST) begin : g_msb_first
    assign shifted = {sr[W-BUS_W-1:0], io.bus};
  end else begin : g_lsb_first
    assign shifted = {io.bus, sr[W-1:BUS_W]};
  end

  // clr forces ready so a beat offered during a flush is consumed and dropped
  // rather than left stalled on the bus.
  assign io.in_ready  = clr | ~(tc & valid_q & ~io.out_ready);
  assign accept       = io.in_valid & io.in_ready & ~clr;
  assign take         = valid_q & io.out_ready;

  assign io.out_valid = valid_q;
  assign io.x         = hold[XW-1:0];
  assign io.y         = hold[W-1:XW];

  beat_counter #(
    .N (NBEATS),
    .W (CW)
  ) u_beat_counter (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (accept),
    .cnt (beat_cnt),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      hold    <= '0;
      valid_q <= 1'b0;
    end else if (clr) begin
      sr      <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept && tc) begin
        hold    <= shifted;
        sr      <= '0;
        valid_q <= 1'b1;
      end else begin
        if (accept) begin
          sr <= shifted;
        end
        if (take) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_stream_assembler.sv
// Directed bench: LSB-first and MSB-first assemblers driven with identical beats.
module tb_byte_stream_assembler;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [1:0] cnt_a;
  logic [1:0] cnt_b;

  int unsigned checks;
  int unsigned failures;

  byte_stream_assembler_if #(.BUS_W(8), .NBEATS(3), .X_BEATS(2)) ia ();
  byte_stream_assembler_if #(.BUS_W(8), .NBEATS(3), .X_BEATS(2)) ib ();

  byte_stream_assembler #(
    .BUS_W(8), .NBEATS(3), .X_BEATS(2), .MSB_FIRST(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .io(ia), .beat_cnt(cnt_a)
  );

  byte_stream_assembler #(
    .BUS_W(8), .NBEATS(3), .X_BEATS(2), .MSB_FIRST(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .io(ib), .beat_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rdy);
    ia.in_valid = v;  ia.bus = d;  ia.out_ready = rdy;
    ib.in_valid = v;  ib.bus = d;  ib.out_ready = rdy;
  endtask

  int unsigned pulses;
  int unsigned first_pulse;
  int unsigned last_pulse;
  int unsigned ready_drops;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(ia.out_valid), 32'h0);
    chk("rst_x", 32'(ia.x), 32'h0);
    chk("rst_y", 32'(ia.y), 32'h0);
    chk("rst_beat_cnt", 32'(cnt_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(ia.in_ready), 32'h1);

    // Single word, consumer always ready
    @(negedge clk); drive(1'b1, 8'h11, 1'b1);
    @(negedge clk); drive(1'b1, 8'h22, 1'b1);
    @(negedge clk); drive(1'b1, 8'h33, 1'b1);
    #1;
    chk("w1_cnt_before_final", 32'(cnt_a), 32'h2);
    chk("w1_ready_before_final", 32'(ia.in_ready), 32'h1);
    @(negedge clk); drive(1'b0, 8'h00, 1'b1);
    chk("w1_out_valid", 32'(ia.out_valid), 32'h1);
    chk("w1_x", 32'(ia.x), 32'h2211);
    chk("w1_y", 32'(ia.y), 32'h33);
    chk("msb_x", 32'(ib.x), 32'h2233);
    chk("msb_y", 32'(ib.y), 32'h11);
    chk("w1_cnt_wrap", 32'(cnt_a), 32'h0);
    @(negedge clk);
    chk("w1_out_valid_drop", 32'(ia.out_valid), 32'h0);

    // Back-pressure: six beats with consumer stalled
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); drive(1'b1, 8'(i), 1'b0);
    end
    @(negedge clk); drive(1'b1, 8'h06, 1'b0);
    #1;
    chk("stall_in_ready", 32'(ia.in_ready), 32'h0);
    chk("stall_x", 32'(ia.x), 32'h0201);
    chk("stall_y", 32'(ia.y), 32'h03);
    chk("stall_cnt", 32'(cnt_a), 32'h2);
    @(negedge clk);
    chk("stall_hold_ready", 32'(ia.in_ready), 32'h0);
    chk("stall_hold_x", 32'(ia.x), 32'h0201);
    drive(1'b1, 8'h06, 1'b1);
    #1;
    chk("release_in_ready", 32'(ia.in_ready), 32'h1);
    @(negedge clk); drive(1'b0, 8'h00, 1'b0);
    chk("release_out_valid", 32'(ia.out_valid), 32'h1);
    chk("release_x", 32'(ia.x), 32'h0504);
    chk("release_y", 32'(ia.y), 32'h06);
    chk("release_cnt", 32'(cnt_a), 32'h0);
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("release_taken", 32'(ia.out_valid), 32'h0);

    // Full throughput: nine back-to-back beats
    pulses = 0;
    first_pulse = 0;
    last_pulse = 0;
    ready_drops = 0;
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) @(negedge clk);
      if (ia.out_valid) begin
        if (pulses == 0) first_pulse = i;
        last_pulse = i;
        pulses++;
      end
      if (i < 9) drive(1'b1, 8'(i), 1'b1);
      else       drive(1'b0, 8'h00, 1'b1);
      #1;
      if (i < 9 && !ia.in_ready) ready_drops++;
    end
    chk("thru_pulses", 32'(pulses), 32'd3);
    chk("thru_first", 32'(first_pulse), 32'd3);
    chk("thru_spacing", 32'(last_pulse - first_pulse), 32'd6);
    chk("thru_ready_drops", 32'(ready_drops), 32'd0);
    chk("thru_last_x", 32'(ia.x), 32'h0706);
    @(negedge clk);
    chk("thru_idle", 32'(ia.out_valid), 32'h0);

    // Flush of a partial word; hold survives clr
    drive(1'b1, 8'h10, 1'b0);
    @(negedge clk); drive(1'b1, 8'h20, 1'b0);
    @(negedge clk);
    chk("clr_cnt_before", 32'(cnt_a), 32'h2);
    clr = 1'b1;
    drive(1'b1, 8'h99, 1'b0);
    #1;
    chk("clr_in_ready", 32'(ia.in_ready), 32'h1);
    @(negedge clk);
    clr = 1'b0;
    chk("clr_cnt_after", 32'(cnt_a), 32'h0);
    chk("clr_hold_kept", 32'(ia.x), 32'h0706);
    drive(1'b1, 8'hAA, 1'b0);
    @(negedge clk); drive(1'b1, 8'hBB, 1'b0);
    @(negedge clk); drive(1'b1, 8'hCC, 1'b0);
    @(negedge clk); drive(1'b1, 8'h55, 1'b0);
    chk("clr_x", 32'(ia.x), 32'hBBAA);
    chk("clr_y", 32'(ia.y), 32'hCC);
    chk("clr_out_valid", 32'(ia.out_valid), 32'h1);

    // Asynchronous reset mid-word with a held word pending
    @(negedge clk); drive(1'b0, 8'h00, 1'b0);
    chk("arst_pre_cnt", 32'(cnt_a), 32'h1);
    chk("arst_pre_valid", 32'(ia.out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(ia.out_valid), 32'h0);
    chk("arst_x", 32'(ia.x), 32'h0);
    chk("arst_y", 32'(ia.y), 32'h0);
    chk("arst_cnt", 32'(cnt_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", 32'(ia.in_ready), 32'h1);
    chk("arst_valid_after", 32'(ia.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
